// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle control unit for the 8-bit CPU.
// Fetches byte-wide instructions from a synchronous program memory, keeps a
// 4 x 8-bit register file plus Z/C flags, and sequences an external 2-bit-op
// ALU. It also handles load-immediate and conditional jumps.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             pulse: leave IDLE/HALT and begin at RESET_PC
//   imem_addr/data    program memory address (= pc) / byte (1-cycle latency)
//   alu_a/b/op        operands reg[ir[3:2]], reg[ir[1:0]] and op (EXEC only)
//   alu_result/zero/carry  combinational ALU response
//   reg_sel/reg_rdata debug register read port
//   zero_flag, carry_flag, busy, halted  status
module alu_seq_ctrl #(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [7:0]          imem_data,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [1:0]          alu_op,
  input  logic [7:0]          alu_result,
  input  logic                alu_zero,
  input  logic                alu_carry,
  input  logic [1:0]          reg_sel,
  output logic [7:0]          reg_rdata,
  output logic                zero_flag,
  output logic                carry_flag,
  output logic                busy,
  output logic                halted
);

  localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_IMM_LATCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          ir;
  logic [7:0]          regs [4];

  logic [3:0]          dec_op;
  logic [3:0]          ir_op;
  logic [1:0]          ir_rd;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] imm_pc;

  assign dec_op = imem_data[7:4];
  assign ir_op  = ir[7:4];
  assign ir_rd  = ir[3:2];
  assign pc_inc = pc + PC_ONE;
  assign imm_pc = PC_WIDTH'(imem_data);

  // Operands come straight from ir so they read the pre-write register value.
  assign imem_addr = pc;
  assign alu_a     = regs[ir[3:2]];
  assign alu_b     = regs[ir[1:0]];
  assign reg_rdata = regs[reg_sel];

  // Sequencer: state, pc, ir, register file, flags and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= PC_RST;
      ir         <= 8'h00;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      alu_op     <= 2'b00;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else begin
      alu_op <= 2'b00;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= PC_RST;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir <= imem_data;
          if (dec_op >= OP_ADD && dec_op <= OP_OR) begin
            // Op is registered here so it is stable for the whole EXEC cycle.
            pc     <= pc_inc;
            alu_op <= 2'(dec_op - 4'd1);
            state  <= S_EXEC;
          end else if (dec_op >= OP_LDI && dec_op <= OP_JC) begin
            pc    <= pc_inc;
            state <= S_IMM;
          end else if (dec_op == OP_HALT) begin
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            pc    <= pc_inc;
            state <= S_FETCH;
          end
        end
        // Memory is reading the immediate address this cycle.
        S_IMM: state <= S_IMM_LATCH;
        S_IMM_LATCH: begin
          state <= S_FETCH;
          case (ir_op)
            OP_LDI: begin
              regs[ir_rd] <= imem_data;
              pc          <= pc_inc;
            end
            OP_JMP:  pc <= imm_pc;
            OP_JZ:   pc <= zero_flag  ? imm_pc : pc_inc;
            OP_JC:   pc <= carry_flag ? imm_pc : pc_inc;
            default: pc <= pc_inc;
          endcase
        end
        S_EXEC: begin
          regs[ir_rd] <= alu_result;
          zero_flag   <= alu_zero;
          carry_flag  <= alu_carry;
          state       <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            pc     <= PC_RST;
            busy   <= 1'b1;
            halted <= 1'b0;
            state  <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: program memory and ALU models, a table of directed
// programs, hand-written multi-cycle corner cases, and random programs
// checked against an instruction-level reference interpreter.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_op;
  logic       alu_zero, alu_carry;
  logic [1:0] reg_sel;
  logic [7:0] reg_rdata;
  logic       zero_flag, carry_flag, busy, halted;

  int total = 0;
  int bad   = 0;

  alu_seq_ctrl #(.PC_WIDTH(8), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .reg_sel(reg_sel), .reg_rdata(reg_rdata),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous program memory.
  logic [7:0] mem [256];
  always @(posedge clk) imem_data <= mem[imem_addr];

  // External ALU.
  logic [8:0] wide;
  always_comb begin
    wide = 9'd0;
    case (alu_op)
      2'b00:   wide = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   wide = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   wide = {1'b0, alu_a & alu_b};
      default: wide = {1'b0, alu_a | alu_b};
    endcase
    alu_result = wide[7:0];
    alu_carry  = wide[8];
    alu_zero   = (wide[7:0] == 8'h00);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic get_reg(input logic [1:0] s, output logic [7:0] v);
    reg_sel = s;
    #1;
    v = reg_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the first FETCH cycle.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until halt; optionally re-pulses start mid-run.
  task automatic run_to_halt(input int extra_start, output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      start = (cyc == extra_start);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_arch(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3,
                            input logic z, input logic c, input logic [7:0] pc);
    logic [7:0] v;
    get_reg(2'd0, v); check({tag, ".r0"}, v, r0);
    get_reg(2'd1, v); check({tag, ".r1"}, v, r1);
    get_reg(2'd2, v); check({tag, ".r2"}, v, r2);
    get_reg(2'd3, v); check({tag, ".r3"}, v, r3);
    check({tag, ".z"}, zero_flag, z);
    check({tag, ".c"}, carry_flag, c);
    check({tag, ".pc"}, imem_addr, pc);
  endtask

  // Program bytes are written left to right in the packed literal.
  task automatic load_prog(input logic [95:0] prog, input int len);
    for (int a = 0; a < 256; a++) mem[a] = 8'hF0;
    for (int i = 0; i < len; i++) mem[i] = prog[8*(len-1-i) +: 8];
  endtask

  typedef struct {
    logic [95:0] prog;
    int          len;
    logic [7:0]  r0, r1, r2, r3;
    logic        z, c;
    logic [7:0]  pc;
    int          cyc;
  } vec_t;

  vec_t vt [10];

  // Instruction-level reference interpreter.
  logic [7:0] m_r [4];
  logic       m_z, m_c, m_halted;
  logic [7:0] m_pc;
  int         m_cyc;

  task automatic model_run();
    logic [7:0] ins, imm, a, b, res;
    logic [3:0] op;
    logic [1:0] rd;
    int         s;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_z = 1'b0; m_c = 1'b0; m_halted = 1'b0; m_pc = 8'h00; m_cyc = 0;
    for (int n = 0; n < 300 && !m_halted; n++) begin
      ins = mem[m_pc];
      op  = ins[7:4];
      rd  = ins[3:2];
      imm = mem[8'(m_pc + 8'd1)];
      a   = m_r[ins[3:2]];
      b   = m_r[ins[1:0]];
      res = 8'h00;
      case (op)
        4'h1, 4'h2, 4'h3, 4'h4: begin
          if (op == 4'h1) begin
            s = int'(a) + int'(b); res = 8'(s); m_c = (s > 255);
          end else if (op == 4'h2) begin
            res = 8'(int'(a) - int'(b)); m_c = (a < b);
          end else if (op == 4'h3) begin
            res = a & b; m_c = 1'b0;
          end else begin
            res = a | b; m_c = 1'b0;
          end
          m_z = (res == 8'h00);
          m_r[rd] = res;
          m_pc = m_pc + 8'd1;
          m_cyc += 3;
        end
        4'h5: begin m_r[rd] = imm; m_pc = m_pc + 8'd2; m_cyc += 4; end
        4'h6: begin m_pc = imm; m_cyc += 4; end
        4'h7: begin m_pc = m_z ? imm : m_pc + 8'd2; m_cyc += 4; end
        4'h8: begin m_pc = m_c ? imm : m_pc + 8'd2; m_cyc += 4; end
        4'hF: begin m_halted = 1'b1; m_cyc += 2; end
        default: begin m_pc = m_pc + 8'd1; m_cyc += 2; end
      endcase
    end
  endtask

  task automatic random_prog();
    logic [7:0] b;
    for (int a = 0; a < 256; a++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 9) == 0) b = 8'hF0;
      mem[a] = b;
    end
  endtask

  initial begin
    int         cyc;
    logic [7:0] v;
    rst = 1'b1; start = 1'b0; reg_sel = 2'd0;
    for (int a = 0; a < 256; a++) mem[a] = 8'hF0;

    vt[0] = '{96'h500F54F111F0,       6, 8'h00, 8'hF1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 13};
    vt[1] = '{96'h58035C052BF0,       6, 8'h00, 8'h00, 8'hFE, 8'h05, 1'b0, 1'b1, 8'h05, 13};
    vt[2] = '{96'h58035C052B4AF0,     7, 8'h00, 8'h00, 8'hFE, 8'h05, 1'b0, 1'b0, 8'h06, 16};
    vt[3] = '{96'h580F5CF03B7020,     7, 8'h00, 8'h00, 8'h00, 8'hF0, 1'b1, 1'b0, 8'h20, 17};
    vt[4] = '{96'h580F5CFF3B7020F0,   8, 8'h00, 8'h00, 8'h0F, 8'hFF, 1'b0, 1'b0, 8'h07, 17};
    vt[5] = '{96'h58035C052B8030,     7, 8'h00, 8'h00, 8'hFE, 8'h05, 1'b0, 1'b1, 8'h30, 17};
    vt[6] = '{96'h58055C032B8030F0,   8, 8'h00, 8'h00, 8'h02, 8'h03, 1'b0, 1'b0, 8'h07, 17};
    vt[7] = '{96'h0090E56010,         5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 12};
    vt[8] = '{96'h500F54F1115A006020, 9, 8'h00, 8'hF1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 21};
    vt[9] = '{96'h540515F0,           4, 8'h00, 8'h0A, 8'h00, 8'h00, 1'b0, 1'b0, 8'h03, 9};

    // Reset state.
    do_reset();
    check_arch("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    check("reset.busy", busy, 1'b0);
    check("reset.halted", halted, 1'b0);
    check("reset.alu_op", alu_op, 2'b00);

    // Directed program table.
    for (int k = 0; k < 10; k++) begin
      load_prog(vt[k].prog, vt[k].len);
      do_reset();
      pulse_start();
      run_to_halt(-1, cyc);
      check($sformatf("vec%0d.cycles", k), cyc, vt[k].cyc);
      check($sformatf("vec%0d.halted", k), halted, 1'b1);
      check_arch($sformatf("vec%0d", k), vt[k].r0, vt[k].r1, vt[k].r2, vt[k].r3,
                 vt[k].z, vt[k].c, vt[k].pc);
    end

    // Start pulse while busy is ignored.
    load_prog(vt[0].prog, vt[0].len);
    do_reset();
    pulse_start();
    run_to_halt(5, cyc);
    check("busy_start.cycles", cyc, 13);
    check_arch("busy_start", 8'h00, 8'hF1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05);

    // PC wrap: NOP at 0, JMP FF, LDI r0 at FF reads its immediate from 0.
    for (int a = 0; a < 256; a++) mem[a] = 8'hF0;
    mem[8'h00] = 8'hAA; mem[8'h01] = 8'h60; mem[8'h02] = 8'hFF; mem[8'hFF] = 8'h50;
    do_reset();
    pulse_start();
    repeat (8) @(negedge clk);
    check("wrap.imm_addr", imem_addr, 8'h00);
    repeat (2) @(negedge clk);
    check("wrap.fetch_addr", imem_addr, 8'h01);
    check("wrap.busy", busy, 1'b1);
    get_reg(2'd0, v);
    check("wrap.r0", v, 8'hAA);

    // Reset in the middle of an EXEC producing 0x55.
    load_prog(96'h50505405_41F0, 6);
    do_reset();
    pulse_start();
    repeat (9) @(negedge clk);
    check("midexec.decode_op", alu_op, 2'b00);
    @(negedge clk);
    check("midexec.exec_op", alu_op, 2'b11);
    check("midexec.alu_a", alu_a, 8'h50);
    check("midexec.alu_b", alu_b, 8'h05);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_arch("midexec", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    check("midexec.busy", busy, 1'b0);
    check("midexec.halted", halted, 1'b0);
    check("midexec.alu_op_after", alu_op, 2'b00);
    repeat (3) @(negedge clk);
    check("midexec.idle_busy", busy, 1'b0);

    // Restart from HALT keeps registers.
    load_prog(96'h5C77F0, 3);
    do_reset();
    pulse_start();
    run_to_halt(-1, cyc);
    check("restart.cycles1", cyc, 6);
    check("restart.pc_halt", imem_addr, 8'h02);
    pulse_start();
    check("restart.busy", busy, 1'b1);
    check("restart.halted", halted, 1'b0);
    check("restart.fetch_addr", imem_addr, 8'h00);
    get_reg(2'd3, v);
    check("restart.r3", v, 8'h77);
    run_to_halt(-1, cyc);
    check("restart.cycles2", cyc, 6);
    get_reg(2'd3, v);
    check("restart.r3_again", v, 8'h77);

    // Random programs against the reference interpreter.
    for (int t = 0; t < 25; t++) begin
      int tries = 0;
      do begin
        random_prog();
        model_run();
        tries++;
      end while (!m_halted && tries < 100);
      do_reset();
      pulse_start();
      run_to_halt(-1, cyc);
      check($sformatf("rnd%0d.halted", t), halted, m_halted);
      check($sformatf("rnd%0d.cycles", t), cyc, m_cyc);
      check_arch($sformatf("rnd%0d", t), m_r[0], m_r[1], m_r[2], m_r[3], m_z, m_c, m_pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
